// File: rtl/display_bcd_pager.sv
// Paged seven-segment front end: a round-robin double-dabble engine keeps a
// BCD bank of every field, two fields are shown per page on HEX5..HEX0, with
// hex/decimal select, halt blinking and a stretched trade LED.

// Formats one three-digit half of the display from its bank entry or raw value.
module display_bcd_pager_half (
  input  logic [11:0] bcd,
  input  logic        ovf,
  input  logic [11:0] raw,
  input  logic        dec_mode,
  input  logic        present,
  output logic [20:0] seg        // {hundreds, tens, ones}, active-low
);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Missing field blanks; hex shows raw digits; decimal suppresses leading zeros.
  always_comb begin
    seg = {3{BLANK}};
    if (!present) begin
      seg = {3{BLANK}};
    end else if (!dec_mode) begin
      seg = {seg7(raw[11:8]), seg7(raw[7:4]), seg7(raw[3:0])};
    end else if (ovf) begin
      seg = {3{DASH}};
    end else begin
      seg[6:0]   = seg7(bcd[3:0]);
      seg[13:7]  = (bcd[11:4] == 8'd0) ? BLANK : seg7(bcd[7:4]);
      seg[20:14] = (bcd[11:8] == 4'd0) ? BLANK : seg7(bcd[11:8]);
    end
  end
endmodule

module display_bcd_pager #(
  parameter int WIDTH          = 8,
  parameter int NUM_FIELDS     = 4,
  parameter int BLINK_DIV      = 25000000,
  parameter int STRETCH_CYCLES = 12500000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_FIELDS*WIDTH-1:0] fields_flat,
  input  logic                        dec_mode,
  input  logic                        page_next,
  input  logic [1:0]                  state,
  input  logic                        halt_flag,
  input  logic                        match_flag,
  input  logic [7:0]                  trade_count,
  output logic [1:0]                  page,
  output logic [6:0]                  HEX0,
  output logic [6:0]                  HEX1,
  output logic [6:0]                  HEX2,
  output logic [6:0]                  HEX3,
  output logic [6:0]                  HEX4,
  output logic [6:0]                  HEX5,
  output logic [9:0]                  LEDR
);
  localparam int NUM_PAGES = (NUM_FIELDS + 1) / 2;
  localparam int IDX_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW        = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} cv_state_t;

  cv_state_t                    cs, ns;
  logic [IDX_W-1:0]             idx;
  logic [WIDTH-1:0]             shreg;
  logic [11:0]                  acc, acc_adj;
  logic [3:0]                   cnt;
  logic                         ovf_pend;
  logic [NUM_FIELDS-1:0][11:0]  bank;
  logic [NUM_FIELDS-1:0]        ovf;

  // Fixed 8-entry views so page-derived indices never leave the array.
  logic [7:0][11:0]             bank_pad, raw_pad;
  logic [7:0]                   ovf_pad;

  for (genvar i = 0; i < 8; i++) begin : g_pad
    if (i < NUM_FIELDS) begin : g_on
      assign bank_pad[i] = bank[i];
      assign ovf_pad[i]  = ovf[i];
      assign raw_pad[i]  = 12'(fields_flat[i*WIDTH +: WIDTH]);
    end else begin : g_off
      assign bank_pad[i] = '0;
      assign ovf_pad[i]  = 1'b0;
      assign raw_pad[i]  = '0;
    end
  end

  // Converter state register.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cs <= S_IDLE;
    else         cs <= ns;

  // Converter next state: LOAD, WIDTH shifts, STORE, repeat.
  always_comb begin
    ns = cs;
    case (cs)
      S_IDLE:  ns = S_LOAD;
      S_LOAD:  ns = S_SHIFT;
      S_SHIFT: if (cnt == 4'd1) ns = S_STORE;
      S_STORE: ns = S_LOAD;
      default: ns = S_IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    acc_adj = acc;
    for (int n = 0; n < 3; n++)
      if (acc[n*4 +: 4] >= 4'd5) acc_adj[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
  end

  // Converter datapath; the bank is only written in STORE, so it never holds a partial result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx      <= '0;
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bank     <= '0;
      ovf      <= '0;
    end else begin
      case (cs)
        S_LOAD: begin
          shreg    <= raw_pad[idx][WIDTH-1:0];
          acc      <= '0;
          cnt      <= 4'(WIDTH);
          ovf_pend <= (raw_pad[idx] > 12'd999);
        end
        S_SHIFT: begin
          {acc, shreg} <= {acc_adj, shreg} << 1;
          cnt          <= cnt - 4'd1;
        end
        S_STORE: begin
          bank[idx] <= acc;
          ovf[idx]  <= ovf_pend;
          idx       <= (idx == IDX_W'(NUM_FIELDS - 1)) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Page index advances on a pulse and wraps after the last page.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) page <= 2'd0;
    else if (page_next && (NUM_PAGES > 1))
      page <= (page == 2'(NUM_PAGES - 1)) ? 2'd0 : page + 2'd1;

  // Half 1 drives HEX5..3 (even field), half 0 drives HEX2..0 (odd field).
  logic [1:0][2:0]  sel;
  logic [1:0][20:0] half_seg;
  assign sel[1] = {page, 1'b0};
  assign sel[0] = {page, 1'b1};

  for (genvar h = 0; h < 2; h++) begin : g_half
    display_bcd_pager_half u_half (
      .bcd      (bank_pad[sel[h]]),
      .ovf      (ovf_pad[sel[h]]),
      .raw      (raw_pad[sel[h]]),
      .dec_mode (dec_mode),
      .present  ({29'd0, sel[h]} < 32'(NUM_FIELDS)),
      .seg      (half_seg[h])
    );
  end

  // Free-running blink divider; phase flips on each wrap.
  logic [BW-1:0] bcnt;
  logic          blink_phase;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      bcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt        <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end

  // Trade LED stretch: a rising edge (re)loads, otherwise count down to zero.
  logic [SW-1:0] scnt;
  logic          match_d;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      scnt    <= '0;
      match_d <= 1'b0;
    end else begin
      match_d <= match_flag;
      if (match_flag && !match_d) scnt <= SW'(STRETCH_CYCLES);
      else if (scnt != '0)        scnt <= scnt - 1'b1;
    end

  // Registered display and status LEDs; halt blanks everything on the odd blink phase.
  logic [8:0] led_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= {6{7'h7F}};
      led_q <= '0;
    end else begin
      if (halt_flag && blink_phase) {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= {6{7'h7F}};
      else {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} <= {half_seg[1], half_seg[0]};
      led_q <= {trade_count[5:0], state, halt_flag};
    end

  assign LEDR = {led_q, (scnt != '0)};

  logic unused_trade;
  assign unused_trade = ^trade_count[7:6];
endmodule

// File: tb/tb_display_bcd_pager.sv
// Bench for display_bcd_pager: instance A (8-bit, 4 fields, fast blink and
// stretch) is tracked cycle by cycle against a schedule-level model; instance
// B (12-bit, 3 fields) covers overflow dashes and the blank odd half.
module tb_display_bcd_pager;
  localparam int WA = 8, NFA = 4, BDA = 4, SCA = 5;
  localparam int WB = 12, NFB = 3;
  localparam logic [6:0] BL = 7'h7F, DS = 7'b0111111;

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NFA*WA-1:0] fields_a;
  logic dec_a, page_next_a, halt_a, match_a;
  logic [1:0] state_a;
  logic [7:0] trade_a;
  logic [1:0] page_a;
  logic [6:0] a_h0, a_h1, a_h2, a_h3, a_h4, a_h5;
  logic [9:0] ledr_a;

  logic [NFB*WB-1:0] fields_b;
  logic dec_b, page_next_b;
  logic [1:0] page_b;
  logic [6:0] b_h0, b_h1, b_h2, b_h3, b_h4, b_h5;
  logic [9:0] ledr_b;

  display_bcd_pager #(.WIDTH(WA), .NUM_FIELDS(NFA), .BLINK_DIV(BDA), .STRETCH_CYCLES(SCA)) dut_a (
    .clk(clk), .resetn(resetn), .fields_flat(fields_a), .dec_mode(dec_a),
    .page_next(page_next_a), .state(state_a), .halt_flag(halt_a), .match_flag(match_a),
    .trade_count(trade_a), .page(page_a), .HEX0(a_h0), .HEX1(a_h1), .HEX2(a_h2),
    .HEX3(a_h3), .HEX4(a_h4), .HEX5(a_h5), .LEDR(ledr_a));

  display_bcd_pager #(.WIDTH(WB), .NUM_FIELDS(NFB), .BLINK_DIV(4), .STRETCH_CYCLES(5)) dut_b (
    .clk(clk), .resetn(resetn), .fields_flat(fields_b), .dec_mode(dec_b),
    .page_next(page_next_b), .state(2'b00), .halt_flag(1'b0), .match_flag(1'b0),
    .trade_count(8'h00), .page(page_b), .HEX0(b_h0), .HEX1(b_h1), .HEX2(b_h2),
    .HEX3(b_h3), .HEX4(b_h4), .HEX5(b_h5), .LEDR(ledr_b));

  int n_cmp = 0, n_fail = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;  1: seg = 7'b1111001;  2: seg = 7'b0100100;  3: seg = 7'b0110000;
      4: seg = 7'b0011001;  5: seg = 7'b0010010;  6: seg = 7'b0000010;  7: seg = 7'b1111000;
      8: seg = 7'b0000000;  9: seg = 7'b0010000; 10: seg = 7'b0001000; 11: seg = 7'b0000011;
      12: seg = 7'b1000110; 13: seg = 7'b0100001; 14: seg = 7'b0000110; default: seg = 7'b0001110;
    endcase
  endfunction

  // Expected three-digit half from a decimal value or a raw hex value.
  function automatic logic [20:0] fmt(input int val, input int raw, input bit dec, input bit pres);
    int h, t, o;
    if (!pres) return {3{BL}};
    if (!dec) return {seg((raw >> 8) & 15), seg((raw >> 4) & 15), seg(raw & 15)};
    if (val > 999) return {3{DS}};
    h = val / 100; t = (val / 10) % 10; o = val % 10;
    return {(h == 0) ? BL : seg(h), (h == 0 && t == 0) ? BL : seg(t), seg(o)};
  endfunction

  function automatic int fld_a(input int i);
    return int'(fields_a[i*WA +: WA]);
  endfunction

  // Model of instance A. Edge n after reset release: conversion k snapshots
  // field k%NFA at edge 2+k*(WA+2) and publishes it WA+1 edges later.
  int n_m = 0, last_load = 0, page_m = 0, snap_v = 0;
  int bank_m [NFA];
  bit match_prev = 0;
  logic [41:0] exp_hex = {6{BL}};
  logic [9:0]  exp_led = '0;
  logic [1:0]  exp_page = '0;

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        n_m = 0; last_load = 0; page_m = 0; snap_v = 0; match_prev = 0;
        for (int i = 0; i < NFA; i++) bank_m[i] = 0;
        exp_hex = {6{BL}}; exp_led = '0; exp_page = '0;
      end else begin
        n_m++;
        if (halt_a && (((n_m - 1) / BDA) % 2 == 1)) exp_hex = {6{BL}};
        else exp_hex = {fmt(bank_m[2*page_m], fld_a(2*page_m), dec_a, 1'b1),
                        fmt(bank_m[2*page_m+1], fld_a(2*page_m+1), dec_a, (2*page_m+1) < NFA)};
        exp_led[9:1] = {trade_a[5:0], state_a, halt_a};
        if (match_a && !match_prev) last_load = n_m;
        match_prev = match_a;
        exp_led[0] = (last_load > 0) && ((n_m - last_load) < SCA);
        if (n_m >= 2 && (n_m - 2) % (WA + 2) == 0) snap_v = fld_a(((n_m - 2) / (WA + 2)) % NFA);
        if (n_m >= 2 && (n_m - 2) % (WA + 2) == WA + 1) bank_m[((n_m - 2) / (WA + 2)) % NFA] = snap_v;
        if (page_next_a) page_m = (page_m + 1) % 2;
        exp_page = 2'(page_m);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a;
    page_next_a = 1; tick(1); page_next_a = 0; tick(1);
  endtask

  int cnt, k;
  bit found;

  initial begin
    fields_a = {8'd42, 8'd255, 8'd0, 8'd3};
    fields_b = {12'd5, 12'd123, 12'd4000};
    dec_a = 1; dec_b = 1; page_next_a = 0; page_next_b = 0;
    halt_a = 0; match_a = 0; state_a = 2'b10; trade_a = 8'h15;
    fork
      forever begin
        @(negedge clk);
        if (chk_on) begin
          chk("hex_a", {a_h5, a_h4, a_h3, a_h2, a_h1, a_h0}, exp_hex);
          chk("ledr_a", ledr_a, exp_led);
          chk("page_a", page_a, exp_page);
        end
      end
    join_none
    chk_on = 1;
    tick(3); resetn = 1;
    tick(5);
    // asynchronous reset in the middle of field 0's shifts
    #2 resetn = 0; #1;
    chk("async_hex", {a_h5, a_h4, a_h3, a_h2, a_h1, a_h0}, {6{BL}});
    chk("async_ledr", ledr_a, 10'd0);
    tick(2); resetn = 1;
    tick(50); @(negedge clk);
    chk("p0_hi", {a_h5, a_h4, a_h3}, {BL, BL, 7'b0110000});
    chk("p0_lo", {a_h2, a_h1, a_h0}, {BL, BL, 7'b1000000});

    pulse_a; @(negedge clk);
    chk("page1", page_a, 2'd1);
    chk("p1_hi", {a_h5, a_h4, a_h3}, {7'b0100100, 7'b0010010, 7'b0010010});
    chk("p1_lo", {a_h2, a_h1, a_h0}, {BL, 7'b0011001, 7'b0100100});
    dec_a = 0; tick(1); @(negedge clk);
    chk("hex_0FF", {a_h5, a_h4, a_h3}, {7'b1000000, 7'b0001110, 7'b0001110});
    chk("hex_02A", {a_h2, a_h1, a_h0}, {7'b1000000, 7'b0100100, 7'b0001000});
    dec_a = 1;
    pulse_a; @(negedge clk);
    chk("page_wrap", page_a, 2'd0);

    // instance B: overflow, 3-field paging, hex of 4000
    chk("b_ovf", {b_h5, b_h4, b_h3}, {3{DS}});
    chk("b_123", {b_h2, b_h1, b_h0}, {7'b1111001, 7'b0100100, 7'b0110000});
    dec_b = 0; tick(1); @(negedge clk);
    chk("b_hexFA0", {b_h5, b_h4, b_h3}, {7'b0001110, 7'b0001000, 7'b1000000});
    chk("b_hex07B", {b_h2, b_h1, b_h0}, {7'b1000000, 7'b1111000, 7'b0000011});
    dec_b = 1;
    page_next_b = 1; tick(1); page_next_b = 0; tick(1); @(negedge clk);
    chk("b_page1", page_b, 2'd1);
    chk("b_p1_hi", {b_h5, b_h4, b_h3}, {BL, BL, 7'b0010010});
    chk("b_p1_lo", {b_h2, b_h1, b_h0}, {3{BL}});

    // change field 0 from 100 to 7 while its conversion is shifting
    found = 0;
    for (k = 0; k < 100 && !found; k++) begin
      tick(1);
      if (n_m >= 1 && ((n_m - 1) % (WA + 2) == 0) && (((n_m - 1) / (WA + 2)) % NFA == 0)) found = 1;
    end
    chk("load0_found", 64'(found), 64'd1);
    fields_a[7:0] = 8'd100;
    tick(3); fields_a[7:0] = 8'd7;
    tick(8); @(negedge clk);
    chk("inflight_100", {a_h5, a_h4, a_h3}, {7'b1111001, 7'b1000000, 7'b1000000});
    tick(NFA * (WA + 2)); @(negedge clk);
    chk("then_7", {a_h5, a_h4, a_h3}, {BL, BL, 7'b1111000});

    // halt blink: half period of 4 cycles
    halt_a = 1; tick(2);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_h0 == BL) cnt++;
    end
    chk("blink_blank_cnt", 64'(cnt), 64'd4);
    chk("halt_led", 64'(ledr_a[1]), 64'd1);
    halt_a = 0; tick(2); @(negedge clk);
    chk("halt_off", a_h0, 7'b1000000);

    // stretch: single pulse
    tick(10);
    match_a = 1; tick(1); match_a = 0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); cnt += int'(ledr_a[0]); end
    chk("stretch_single", 64'(cnt), 64'd5);
    // second pulse three cycles after the first reloads
    tick(10);
    match_a = 1; tick(1); match_a = 0; tick(2);
    match_a = 1; tick(1); match_a = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); cnt += int'(ledr_a[0]); end
    chk("stretch_reload", 64'(cnt), 64'd5);
    // held level loads only once
    tick(10);
    match_a = 1; tick(1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); cnt += int'(ledr_a[0]);
      tick(1);
      if (i == 19) match_a = 0;
    end
    chk("stretch_level", 64'(cnt), 64'd5);

    trade_a = 8'hFF; tick(1); @(negedge clk);
    chk("trade_3F", 64'(ledr_a[9:4]), 64'h3F);

    tick(5);
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
